// File: rtl/key_sched_reg_file_pkg.sv
// Shared types and default sizing for the AES key-schedule register file.
// Defaults cover AES-256: 60 words of 32 bits, 4 words per round key.
package key_sched_reg_file_pkg;

  typedef enum logic [1:0] {
    KS_IDLE,
    KS_FETCH,
    KS_DONE
  } ks_state_e;

  localparam int KS_DATA_W = 32;
  localparam int KS_DEPTH  = 60;
  localparam int KS_ADDR_W = 6;
  localparam int KS_WPK    = 4;
  localparam int KS_RND_W  = 4;

endpackage

// File: rtl/key_sched_reg_file_if.sv
// Bus bundle between the key-expansion writer/round-key consumer and the register file.
// The master drives the write, read and fetch requests; the slave returns data.
interface key_sched_reg_file_if
  import key_sched_reg_file_pkg::*;
#(
  parameter int DATA_W = KS_DATA_W,
  parameter int ADDR_W = KS_ADDR_W,
  parameter int WPK    = KS_WPK,
  parameter int RND_W  = KS_RND_W
);

  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic [ADDR_W-1:0]       rd_addr;
  logic [DATA_W-1:0]       rd_data;
  logic                    rk_req;
  logic [RND_W-1:0]        rk_round;
  logic                    rk_busy;
  logic                    rk_valid;
  logic [WPK*DATA_W-1:0]   rk_data;
  logic                    rk_err;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, rk_req, rk_round,
    input  rd_data, rk_busy, rk_valid, rk_data, rk_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, rk_req, rk_round,
    output rd_data, rk_busy, rk_valid, rk_data, rk_err
  );

endinterface

// File: rtl/key_sched_reg_file_word_sel_mux.sv
// DEPTH:1 combinational word selector over a flattened word bus.
// Selects that match no stored word return zero.
module word_sel_mux #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 60,
  parameter int SEL_W  = 6
) (
  input  logic [DEPTH*DATA_W-1:0] words_i,
  input  logic [SEL_W-1:0]        sel_i,
  output logic [DATA_W-1:0]       word_o
);

  always_comb begin
    word_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_i == SEL_W'(i)) begin
        word_o = words_i[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/key_sched_reg_file.sv
// Register file for expanded AES key-schedule words with a registered random read
// port and a fetch engine that assembles WPK consecutive words into one round key.
module key_sched_reg_file
  import key_sched_reg_file_pkg::*;
#(
  parameter int DATA_W = KS_DATA_W,
  parameter int DEPTH  = KS_DEPTH,
  parameter int ADDR_W = KS_ADDR_W,
  parameter int WPK    = KS_WPK,
  parameter int RND_W  = KS_RND_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  key_sched_reg_file_if.slave  bus
);

  localparam int KEY_W  = WPK * DATA_W;
  localparam int BASE_W = RND_W + $clog2(WPK) + 1;
  localparam int CNT_W  = $clog2(WPK) + 1;

  logic [DATA_W-1:0]       mem_q [DEPTH];
  logic [DATA_W-1:0]       mem_d [DEPTH];
  logic [DEPTH*DATA_W-1:0] mem_flat;

  ks_state_e               state_q, state_d;
  logic [BASE_W-1:0]       base_q, base_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [KEY_W-1:0]        rk_data_q, rk_data_d;
  logic                    rk_err_q, rk_err_d;
  logic                    rk_valid_q, rk_valid_d;
  logic [DATA_W-1:0]       rd_data_q, rd_data_d;

  logic [BASE_W-1:0]       req_base;
  logic                    req_err;
  logic [BASE_W-1:0]       fetch_addr;
  logic [DATA_W-1:0]       fetch_word;
  logic [DATA_W-1:0]       rd_word;

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign mem_flat[g*DATA_W +: DATA_W] = mem_q[g];
  end

  word_sel_mux #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .SEL_W  (ADDR_W)
  ) u_rd_mux (
    .words_i (mem_flat),
    .sel_i   (bus.rd_addr),
    .word_o  (rd_word)
  );

  word_sel_mux #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .SEL_W  (BASE_W)
  ) u_fetch_mux (
    .words_i (mem_flat),
    .sel_i   (fetch_addr),
    .word_o  (fetch_word)
  );

  // The base is kept wide enough that an oversized round index is flagged, not wrapped.
  assign req_base   = BASE_W'(bus.rk_round) * BASE_W'(WPK);
  assign req_err    = (32'(req_base) + 32'(WPK)) > 32'(DEPTH);
  assign fetch_addr = base_q + BASE_W'(cnt_q);

  always_comb begin
    mem_d = mem_q;
    if (bus.wr_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.wr_addr == ADDR_W'(i)) begin
          mem_d[i] = bus.wr_data;
        end
      end
    end
  end

  assign rd_data_d = rd_word;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    cnt_d      = cnt_q;
    rk_data_d  = rk_data_q;
    rk_err_d   = rk_err_q;
    rk_valid_d = 1'b0;
    case (state_q)
      KS_IDLE: begin
        if (bus.rk_req) begin
          base_d = req_base;
          cnt_d  = '0;
          if (req_err) begin
            rk_err_d  = 1'b1;
            rk_data_d = '0;
            state_d   = KS_DONE;
          end else begin
            rk_err_d = 1'b0;
            state_d  = KS_FETCH;
          end
        end
      end
      KS_FETCH: begin
        // Shifting in from the LSB side leaves the first fetched word in the MSB slot.
        rk_data_d = (rk_data_q << DATA_W) | KEY_W'(fetch_word);
        if (cnt_q == CNT_W'(WPK - 1)) begin
          state_d = KS_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      KS_DONE: begin
        rk_valid_d = 1'b1;
        state_d    = KS_IDLE;
      end
      default: begin
        state_d = KS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q      <= '{default: '0};
      state_q    <= KS_IDLE;
      base_q     <= '0;
      cnt_q      <= '0;
      rk_data_q  <= '0;
      rk_err_q   <= 1'b0;
      rk_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      mem_q      <= mem_d;
      state_q    <= state_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      rk_data_q  <= rk_data_d;
      rk_err_q   <= rk_err_d;
      rk_valid_q <= rk_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Busy spans the valid cycle itself, which is already back in IDLE.
  assign bus.rk_busy  = (state_q != KS_IDLE) || rk_valid_q;
  assign bus.rk_valid = rk_valid_q;
  assign bus.rk_data  = rk_data_q;
  assign bus.rk_err   = rk_err_q;
  assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_key_sched_reg_file.sv
// Scoreboard bench for key_sched_reg_file: a timeline model of memory and fetches
// pushes expected results; a monitor pops and compares whenever the DUT presents data.
module tb_key_sched_reg_file;
  import key_sched_reg_file_pkg::*;

  localparam int DATA_W = KS_DATA_W;
  localparam int DEPTH  = KS_DEPTH;
  localparam int ADDR_W = KS_ADDR_W;
  localparam int WPK    = KS_WPK;
  localparam int RND_W  = KS_RND_W;
  localparam int KEY_W  = WPK * DATA_W;

  typedef struct {
    logic [KEY_W-1:0] data;
    logic             err;
    int               edge_n;
  } rk_exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  key_sched_reg_file_if #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .WPK    (WPK),
    .RND_W  (RND_W)
  ) bus ();

  key_sched_reg_file #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WPK    (WPK),
    .RND_W  (RND_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;

  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [DATA_W-1:0] rd_q [$];
  rk_exp_t           rk_q [$];

  bit               fetch_active = 1'b0;
  int               f_edge = 0;
  int               f_base = 0;
  logic [KEY_W-1:0] f_acc = '0;
  int               ready_edge = 0;
  int               busy_until = 0;

  int               valid_count = 0;
  int               last_valid_edge = 0;
  int               last_req_edge = 0;
  logic [KEY_W-1:0] last_rk_data = '0;
  logic             last_rk_err = 1'b0;

  task automatic checkOutput(input string name, input logic [KEY_W-1:0] actual,
                             input logic [KEY_W-1:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    rd_q.delete();
    rk_q.delete();
    fetch_active = 1'b0;
    ready_edge   = 0;
    busy_until   = 0;
  endtask

  // One cycle of stimulus: drive at the falling edge, update the model for the coming rising edge.
  task automatic applyStimulus(input bit we, input int wa, input logic [DATA_W-1:0] wd,
                               input int ra, input bit req, input int rnd);
    int      u;
    int      base;
    rk_exp_t e;
    @(negedge clk);
    u = cyc + 1;
    bus.wr_en    = we;
    bus.wr_addr  = ADDR_W'(wa);
    bus.wr_data  = wd;
    bus.rd_addr  = ADDR_W'(ra);
    bus.rk_req   = req;
    bus.rk_round = RND_W'(rnd);

    if (fetch_active && u > f_edge && u <= f_edge + WPK) begin
      f_acc = (f_acc << DATA_W) | KEY_W'(model_mem[f_base + (u - f_edge - 1)]);
      if (u == f_edge + WPK) begin
        e.data = f_acc; e.err = 1'b0; e.edge_n = u + 1;
        rk_q.push_back(e);
        fetch_active = 1'b0;
      end
    end

    rd_q.push_back((ra < DEPTH) ? model_mem[ra] : '0);

    if (req && u >= ready_edge) begin
      last_req_edge = u;
      base = rnd * WPK;
      if (base + WPK > DEPTH) begin
        e.data = '0; e.err = 1'b1; e.edge_n = u + 1;
        rk_q.push_back(e);
        ready_edge = u + 2;
      end else begin
        fetch_active = 1'b1;
        f_edge = u;
        f_base = base;
        f_acc  = '0;
        ready_edge = u + WPK + 2;
      end
      busy_until = ready_edge;
    end

    if (we && wa < DEPTH) model_mem[wa] = wd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, '0, 0, 1'b0, 0);
  endtask

  task automatic resetPulse();
    @(negedge clk);
    rst_n = 1'b0;
    modelReset();
    bus.wr_en  = 1'b0;
    bus.rk_req = 1'b0;
    #1;
    checkOutput("reset_rd_data", bus.rd_data, '0);
    checkOutput("reset_rk_busy", bus.rk_busy, '0);
    checkOutput("reset_rk_valid", bus.rk_valid, '0);
    checkOutput("reset_rk_data", bus.rk_data, '0);
    checkOutput("reset_rk_err", bus.rk_err, '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compares whatever the DUT presents just after each rising edge.
  initial begin
    rk_exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rd_q.size() > 0) checkOutput("rd_data", bus.rd_data, rd_q.pop_front());
      checkOutput("rk_busy", bus.rk_busy, (cyc < busy_until) ? 1'b1 : 1'b0);
      if (bus.rk_valid) begin
        valid_count++;
        last_valid_edge = cyc;
        last_rk_data = bus.rk_data;
        last_rk_err  = bus.rk_err;
        if (rk_q.size() == 0) begin
          checkOutput("rk_valid_unexpected", bus.rk_valid, 1'b0);
        end else begin
          e = rk_q.pop_front();
          checkOutput("rk_data", bus.rk_data, e.data);
          checkOutput("rk_err", bus.rk_err, e.err);
          checkOutput("rk_valid_edge", cyc, e.edge_n);
        end
      end else if (rk_q.size() > 0 && rk_q[0].edge_n <= cyc) begin
        checkOutput("rk_valid_missing", bus.rk_valid, 1'b1);
        void'(rk_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached before end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int vc;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_addr = '0; bus.rk_req = 1'b0; bus.rk_round = '0;
    modelReset();
    #2;
    checkOutput("init_rd_data", bus.rd_data, '0);
    checkOutput("init_rk_busy", bus.rk_busy, '0);
    checkOutput("init_rk_valid", bus.rk_valid, '0);
    checkOutput("init_rk_data", bus.rk_data, '0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] read all words after reset");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 0, '0, i, 1'b0, 0);

    $display("[TB] fill memory and fetch round 3");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, i, 32'hA500_0000 + DATA_W'(i), 0, 1'b0, 0);
    applyStimulus(1'b0, 0, '0, 0, 1'b1, 3);
    idle(8);
    checkOutput("round3_data", last_rk_data, 128'hA500000C_A500000D_A500000E_A500000F);
    checkOutput("round3_err", last_rk_err, 1'b0);
    checkOutput("round3_latency", last_valid_edge - last_req_edge, WPK + 1);

    $display("[TB] out-of-range fetch and write");
    applyStimulus(1'b0, 0, '0, 0, 1'b1, 15);
    idle(4);
    checkOutput("round15_err", last_rk_err, 1'b1);
    checkOutput("round15_data", last_rk_data, '0);
    checkOutput("round15_latency", last_valid_edge - last_req_edge, 1);
    applyStimulus(1'b1, 63, 32'h1234_5678, 63, 1'b0, 0);
    for (int i = 0; i < 64; i++) applyStimulus(1'b0, 0, '0, i, 1'b0, 0);

    $display("[TB] writes racing a round-1 fetch");
    applyStimulus(1'b0, 0, '0, 0, 1'b1, 1);
    idle(2);
    applyStimulus(1'b1, 7, 32'hDEAD_BEEF, 0, 1'b0, 0);
    idle(5);
    checkOutput("early_write_lsb", last_rk_data[DATA_W-1:0], 32'hDEAD_BEEF);
    checkOutput("early_write_msb", last_rk_data[KEY_W-1 -: DATA_W], 32'hA500_0004);
    applyStimulus(1'b0, 0, '0, 0, 1'b1, 1);
    idle(3);
    applyStimulus(1'b1, 7, 32'hCAFE_F00D, 0, 1'b0, 0);
    idle(5);
    checkOutput("same_cycle_write_lsb", last_rk_data[DATA_W-1:0], 32'hDEAD_BEEF);
    applyStimulus(1'b1, 5, 32'h55AA_55AA, 5, 1'b0, 0);
    applyStimulus(1'b0, 0, '0, 5, 1'b0, 0);
    idle(1);

    $display("[TB] requests while busy are ignored");
    vc = valid_count;
    applyStimulus(1'b0, 0, '0, 0, 1'b1, 2);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 0, '0, 0, 1'b1, 3);
    idle(6);
    checkOutput("busy_single_valid", valid_count - vc, 1);

    $display("[TB] reset in the middle of a fetch");
    vc = valid_count;
    applyStimulus(1'b0, 0, '0, 0, 1'b1, 2);
    idle(2);
    resetPulse();
    idle(8);
    checkOutput("reset_no_valid", valid_count - vc, 0);
    for (int i = 0; i < WPK; i++) applyStimulus(1'b1, i, $urandom, i, 1'b0, 0);
    applyStimulus(1'b0, 0, '0, 0, 1'b1, 0);
    idle(8);
    checkOutput("post_reset_fetch", valid_count - vc, 1);
    checkOutput("post_reset_latency", last_valid_edge - last_req_edge, WPK + 1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 63), $urandom,
                    $urandom_range(0, 63), $urandom_range(0, 3) == 0, $urandom_range(0, 15));
    end
    idle(10);
    checkOutput("rk_queue_drained", rk_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
